// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
// Holds the FSM state, the resolved control-flow operation and offset sign extension.
package pc_pkg;

  typedef enum logic {
    RUN,
    HALTED
  } pc_state_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_JUMP,
    OP_BRANCH,
    OP_CALL,
    OP_RET
  } pc_op_t;

  // Sign-extends the low w bits of val to 32 bits; callers cast the result down to the PC width.
  function automatic logic [31:0] sext_off(input logic [31:0] val, input int unsigned w);
    logic signed [31:0] t;
    t = val << (32 - w);
    return t >>> (32 - w);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the decode/control unit (master) and pc_unit (slave).
interface pc_unit_if #(
  parameter int D     = 10,
  parameter int OFF_W = 8
);
  logic             stall;
  logic             jump_en;
  logic             branch_en;
  logic             call_en;
  logic             ret_en;
  logic             halt;
  logic [D-1:0]     target;
  logic [OFF_W-1:0] offset;
  logic [D-1:0]     prog_ctr;
  logic             halted;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, jump_en, branch_en, call_en, ret_en, halt, target, offset,
    input  prog_ctr, halted, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, jump_en, branch_en, call_en, ret_en, halt, target, offset,
    output prog_ctr, halted, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// The top of stack is presented combinationally on pop_data.
module pc_ras #(
  parameter int D         = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [D-1:0]  mem_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // ptr_q is the next write slot; when full it also points at the oldest entry.
  assign pop_data = mem_q[ptr_q - PW'(1)];
  assign full     = (cnt_q == CW'(RAS_DEPTH));
  assign empty    = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: increment, jump, relative branch, call/return via RAS,
// stall and sticky halt. One operation per cycle, resolved by fixed priority.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          D          = 10,
  parameter int          OFF_W      = 8,
  parameter int          RAS_DEPTH  = 4,
  parameter int unsigned START_ADDR = 0
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  pc_state_t    state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  pc_op_t       op;

  logic         ras_push, ras_pop, ras_full, ras_empty;
  logic [D-1:0] ras_top;
  logic [D-1:0] pc_inc;
  logic [D-1:0] pc_branch;

  assign pc_inc    = pc_q + D'(1);
  assign pc_branch = pc_q + D'(sext_off(32'(bus.offset), OFF_W));

  pc_ras #(
    .D         (D),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .pop_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // A stalled or halted cycle resolves to OP_HOLD, so lower-priority requests have no side effects.
  always_comb begin
    op = OP_HOLD;
    if (state_q == RUN && !bus.stall) begin
      if      (bus.halt)      op = OP_HOLD;
      else if (bus.ret_en)    op = OP_RET;
      else if (bus.call_en)   op = OP_CALL;
      else if (bus.jump_en)   op = OP_JUMP;
      else if (bus.branch_en) op = OP_BRANCH;
      else                    op = OP_INC;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (state_q == RUN && !bus.stall && bus.halt) state_d = HALTED;
    case (op)
      OP_INC:    pc_d = pc_inc;
      OP_JUMP:   pc_d = bus.target;
      OP_BRANCH: pc_d = pc_branch;
      OP_CALL: begin
        ras_push = 1'b1;
        pc_d     = bus.target;
        if (ras_full) ovf_d = 1'b1;
      end
      OP_RET: begin
        if (ras_empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          ras_pop = 1'b1;
          pc_d    = ras_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= D'(START_ADDR);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.prog_ctr      = pc_q;
  assign bus.halted        = (state_q == HALTED);
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised next-generation program counter for the custom CPU fetch stage. It supports the following control-flow operations:
- sequential increment
- absolute jump
- PC-relative signed branch
- call/return through an internal circular return-address stack (RAS)
- pipeline stall
- sticky halt

It feeds instruction-memory address prog_ctr and is driven by the decode/control unit.

Parameters:
D, 10, program-counter/address width in bits
OFF_W, 8, width of signed relative branch offset (OFF_W <= D)
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)
START_ADDR, 0, prog_ctr value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and RAS this cycle
jump_en  input  1  absolute jump to target
branch_en  input  1  relative branch by offset
call_en  input  1  push return address, jump to target
ret_en  input  1  pop return address into PC
halt  input  1  enter HALTED state
target  input  D  absolute jump/call destination
offset  input  OFF_W  two's-complement branch offset relative to current prog_ctr
prog_ctr  output  D  current PC (registered)
halted  output  1  high while in HALTED
ras_overflow  output  1  sticky: call issued with RAS full
ras_underflow  output  1  sticky: return issued with RAS empty

Behaviour:
- Reset values: prog_ctr=START_ADDR, state=RUN, halted=0, ras_overflow=0, ras_underflow=0, RAS count=0, RAS pointer=0. Reset overrides everything, including mid-stall and HALTED.
- All outputs are registered. A control input sampled at edge N is reflected in prog_ctr after edge N; latency is 1 cycle.
- States:
  - RUN: normal operation.
  - HALTED: prog_ctr frozen, all control inputs ignored, RAS frozen, halted=1.
  - RUN->HALTED when halt=1 and stall=0. HALTED exits only via reset.
- Priority in RUN when stall=0: halt > ret_en > call_en > jump_en > branch_en > increment. Only the highest-priority asserted operation takes effect; lower ones are dropped with no side effects.
- halt: prog_ctr holds its current value; it does not increment on the halting edge.
- stall=1 in RUN: prog_ctr, RAS and flags are all unchanged, and all other inputs including halt are ignored.
- increment: prog_ctr <= prog_ctr+1 mod 2^D. Address 2^D-1 wraps to 0.
- jump: prog_ctr <= target.
- branch: prog_ctr <= prog_ctr + sign_extend(offset) mod 2^D. Wrap is silent in both directions.
- call:
  - Push (prog_ctr+1 mod 2^D), then prog_ctr <= target.
  - If RAS is full (count==RAS_DEPTH), the oldest entry is overwritten (circular), count stays at RAS_DEPTH, and ras_overflow is set.
- ret:
  - If count>0: pop the top entry into prog_ctr and decrement count.
  - If count==0: prog_ctr increments normally, the pointer and count are unchanged, and ras_underflow is set.
- Flags are sticky until reset and do not by themselves halt the core.
- Overflow followed by RAS_DEPTH returns yields the RAS_DEPTH most recent return addresses in LIFO order. A further return underflows.

Decomposition:
- Package pc_pkg holds:
  - typedef enum logic {RUN, HALTED} pc_state_t
  - typedef enum of resolved operation: OP_HOLD, OP_INC, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET
  - function sign-extending an OFF_W offset to D bits
- Sub-module pc_ras owns the circular stack:
  - Parameters D and RAS_DEPTH.
  - Ports: clk, reset, push, pop, push_data, pop_data, full, empty.
  - Simultaneous push and pop are never issued by pc_unit.
- pc_unit contains the operation-priority decode, the state register and the flag registers.

Test Plan:
- Reset, then 5 idle cycles -> prog_ctr 0,1,2,3,4,5. With D=4, run from 14 -> 15,0,1 (wrap).
- At PC=20, branch offset=-8 -> 12. At PC=5, branch offset=-8 -> 1021 (D=10 wrap). jump_en+branch_en together, target=100 -> 100.
- At PC=10, call target=200, then 3 increments, then ret -> 200,201,202,203,11. RAS empty, no flags.
- 5 nested calls from PCs 1,2,3,4,5 (RAS_DEPTH=4) -> ras_overflow=1. Then 4 rets return 6,5,4,3; 5th ret -> ras_underflow=1 and PC increments.
- stall held 3 cycles with jump_en=1, target=50 -> prog_ctr unchanged. Release stall with jump_en=1 -> 50 on next edge.
- halt at PC=30 -> prog_ctr stays 30, halted=1, jump/call ignored. reset asserted -> prog_ctr=START_ADDR, halted=0, flags cleared.
